// File: rtl/sw_resp_pkg.sv
// Shared types for the single-wire half-duplex responder.
// Optional parity bit in both directions when SW_RESP_PARITY_EN is defined.
package sw_resp_pkg;

`ifdef SW_RESP_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RX_START = 4'd1,
    RX_DATA  = 4'd2,
    RX_STOP  = 4'd3,
    TURN     = 4'd4,
    TX_START = 4'd5,
    TX_DATA  = 4'd6,
    TX_STOP  = 4'd7
`ifdef SW_RESP_PARITY_EN
    ,
    RX_PAR   = 4'd8,
    TX_PAR   = 4'd9
`endif
  } state_t;

  // Bits on the wire per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned dw);
    return dw + 2 + PAR_BITS;
  endfunction

endpackage

// File: rtl/sw_resp_iob.sv
// Pad-ring flops for the single-wire responder: output, output-enable and
// input registers plus the tristate driver, kept as one hierarchy for IO packing.
module sw_resp_iob (
  input  logic clk,
  input  logic rst_n,
  input  logic out_d,
  input  logic oe_d,
  output logic pad_in_r,
  inout  wire  pad
);

  logic pad_out_r;
  logic pad_oe_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_out_r <= 1'b1;
      pad_oe_r  <= 1'b0;
      pad_in_r  <= 1'b1;
    end else begin
      pad_out_r <= out_d;
      pad_oe_r  <= oe_d;
      pad_in_r  <= pad;
    end
  end

  assign pad = pad_oe_r ? pad_out_r : 1'bz;

endmodule

// File: rtl/sw_half_duplex_resp.sv
// Single-wire half-duplex serial responder: receives an initiator frame and
// optionally answers after a turnaround gap. Parity via SW_RESP_PARITY_EN.
module sw_half_duplex_resp #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned TA_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  inout  wire           pad,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          err,
  output logic          busy
);

  import sw_resp_pkg::*;

  localparam int unsigned TW       = $clog2(BIT_CYCLES + 1);
  localparam int unsigned IW       = $clog2(DW + 1);
  localparam int unsigned TURN_CYC = (BIT_CYCLES - BIT_CYCLES / 2) + TA_BITS * BIT_CYCLES;
  localparam int unsigned NW       = $clog2(TURN_CYC + 1);

  localparam logic [TW-1:0] T_FULL = TW'(BIT_CYCLES);
  localparam logic [TW-1:0] T_HALF = TW'(BIT_CYCLES / 2);
  localparam logic [IW-1:0] I_LAST = IW'(DW - 1);
  localparam logic [NW-1:0] N_TURN = NW'(TURN_CYC);

  state_t        state, state_n;
  logic [TW-1:0] tmr;
  logic [IW-1:0] idx, idx_n;
  logic [NW-1:0] turn_cnt;
  logic          pad_in_r, pad_in_d;
  logic [DW-1:0] rx_sh, tx_sh, hold_data;
  logic          hold_full;
  logic          load, stop_good, tx_bit;
  logic          restart, rx_shift, rx_ok, rx_bad, tx_load;
  logic          out_d, oe_d;
`ifdef SW_RESP_PARITY_EN
  logic          par_sample, par_bad;
`endif

  sw_resp_iob u_iob (
    .clk      (clk),
    .rst_n    (rst_n),
    .out_d    (out_d),
    .oe_d     (oe_d),
    .pad_in_r (pad_in_r),
    .pad      (pad)
  );

  assign load     = tx_valid & ~hold_full;
  assign tx_ready = ~hold_full;
  assign busy     = (state != IDLE);

`ifdef SW_RESP_PARITY_EN
  assign stop_good = pad_in_r & ~par_bad;
`else
  assign stop_good = pad_in_r;
`endif

  always_comb begin
    state_n  = state;
    restart  = 1'b0;
    rx_shift = 1'b0;
    rx_ok    = 1'b0;
    rx_bad   = 1'b0;
    tx_load  = 1'b0;
`ifdef SW_RESP_PARITY_EN
    par_sample = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (pad_in_d && !pad_in_r) begin
          state_n = RX_START;
          restart = 1'b1;
        end
      end
      RX_START: begin
        if (tmr == T_HALF) begin
          restart = 1'b1;
          state_n = pad_in_r ? IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tmr == T_FULL) begin
          restart  = 1'b1;
          rx_shift = 1'b1;
          if (idx == I_LAST) begin
`ifdef SW_RESP_PARITY_EN
            state_n = RX_PAR;
`else
            state_n = RX_STOP;
`endif
          end
        end
      end
`ifdef SW_RESP_PARITY_EN
      RX_PAR: begin
        if (tmr == T_FULL) begin
          restart    = 1'b1;
          par_sample = 1'b1;
          state_n    = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (tmr == T_FULL) begin
          restart = 1'b1;
          if (stop_good) begin
            rx_ok   = 1'b1;
            state_n = hold_full ? TURN : IDLE;
          end else begin
            rx_bad  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      TURN: begin
        if (turn_cnt == N_TURN) begin
          restart = 1'b1;
          tx_load = 1'b1;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (tmr == T_FULL) begin
          restart = 1'b1;
          state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tmr == T_FULL) begin
          restart = 1'b1;
          if (idx == I_LAST) begin
`ifdef SW_RESP_PARITY_EN
            state_n = TX_PAR;
`else
            state_n = TX_STOP;
`endif
          end
        end
      end
`ifdef SW_RESP_PARITY_EN
      TX_PAR: begin
        if (tmr == T_FULL) begin
          restart = 1'b1;
          state_n = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (tmr == T_FULL) begin
          restart = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit index is zero outside the data states and steps at each bit boundary.
  always_comb begin
    idx_n = '0;
    if (state == RX_DATA || state == TX_DATA) begin
      idx_n = restart ? idx + 1'b1 : idx;
    end
  end

  assign tx_bit = |((tx_sh >> idx_n) & DW'(1));

  // Pad drive is decoded from the next state so the registered output
  // enable lines up exactly with the TX states.
  always_comb begin
    oe_d  = 1'b0;
    out_d = 1'b1;
    unique case (state_n)
      TX_START: begin
        oe_d  = 1'b1;
        out_d = 1'b0;
      end
      TX_DATA: begin
        oe_d  = 1'b1;
        out_d = tx_bit;
      end
`ifdef SW_RESP_PARITY_EN
      TX_PAR: begin
        oe_d  = 1'b1;
        out_d = ^tx_sh;
      end
`endif
      TX_STOP: begin
        oe_d  = 1'b1;
        out_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr       <= '0;
      idx       <= '0;
      turn_cnt  <= '0;
      pad_in_d  <= 1'b1;
      rx_sh     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      err       <= 1'b0;
      tx_sh     <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      pad_in_d <= pad_in_r;
      idx      <= idx_n;
      rx_valid <= rx_ok;
      err      <= rx_bad;

      if (restart) begin
        tmr <= TW'(1);
      end else if (state != IDLE && state != TURN) begin
        tmr <= tmr + 1'b1;
      end

      if (state == TURN) begin
        turn_cnt <= turn_cnt + 1'b1;
      end else begin
        turn_cnt <= NW'(1);
      end

      if (rx_shift) begin
        rx_sh <= {pad_in_r, rx_sh[DW-1:1]};
      end
      if (rx_ok) begin
        rx_data <= rx_sh;
      end

      if (tx_load) begin
        tx_sh     <= hold_data;
        hold_full <= 1'b0;
      end else if (load) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

`ifdef SW_RESP_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad <= 1'b0;
    end else if (par_sample) begin
      par_bad <= pad_in_r ^ (^rx_sh);
    end
  end
`endif

endmodule

// File: tb/tb_sw_half_duplex_resp.sv
// Self-checking bench for sw_half_duplex_resp: a frame-level timeline model
// plus literal spot checks. Honours SW_RESP_PARITY_EN when defined.
module tb_sw_half_duplex_resp;

  localparam int BC   = 4;
  localparam int DW   = 8;
  localparam int TA   = 1;
`ifdef SW_RESP_PARITY_EN
  localparam int PB   = 1;
`else
  localparam int PB   = 0;
`endif
  localparam int NB   = DW + 2 + PB;
  localparam int GAP  = (BC - BC / 2) + TA * BC;
  localparam int NCYC = 4096;
  localparam int LAST = NCYC - 1;

  localparam int F_OE = 0, F_OUT = 1, F_BUSY = 2, F_RXV = 3, F_ERR = 4, F_RDY = 5, F_RXD = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          err;
  logic          busy;
  logic          init_low = 1'b0;
  logic          chk_en = 1'b0;

  wire pad;
  pullup (pad);
  assign pad = init_low ? 1'b0 : 1'bz;

  sw_half_duplex_resp #(
    .BIT_CYCLES (BC),
    .DW         (DW),
    .TA_BITS    (TA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pad      (pad),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .err      (err),
    .busy     (busy)
  );

  logic probe_oe;
  assign probe_oe = dut.u_iob.pad_oe_r;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected per-cycle timeline, written ahead of time by the frame model.
  typedef struct packed {
    logic          oe;
    logic          out;
    logic          busy;
    logic          rxv;
    logic          err;
    logic          rdy;
    logic [DW-1:0] rxd;
  } exp_t;
  exp_t ex [NCYC];

  logic          m_full = 1'b0;
  logic [DW-1:0] m_hold = '0;

  function automatic void setf(input int a, input int b, input int f, input logic [DW-1:0] v);
    for (int c = a; c <= b && c < NCYC; c++) begin
      case (f)
        F_OE:    ex[c].oe   = v[0];
        F_OUT:   ex[c].out  = v[0];
        F_BUSY:  ex[c].busy = v[0];
        F_RXV:   ex[c].rxv  = v[0];
        F_ERR:   ex[c].err  = v[0];
        F_RDY:   ex[c].rdy  = v[0];
        default: ex[c].rxd  = v;
      endcase
    end
  endfunction

  function automatic void model_reset(input int from);
    for (int c = from; c < NCYC; c++) ex[c] = '{oe: 1'b0, out: 1'b1, busy: 1'b0, rxv: 1'b0,
                                              err: 1'b0, rdy: 1'b1, rxd: '0};
    m_full = 1'b0;
  endfunction

  // Response: start, data LSB first, optional even parity, stop; begins GAP
  // cycles after the stop-sample cycle s has passed.
  function automatic void model_resp(input int s, input logic [DW-1:0] d);
    logic [NB-1:0] fb;
    int            t0;
    fb = '0;
    for (int i = 0; i < DW; i++) fb[1 + i] = d[i];
    if (PB == 1) fb[DW + 1] = ^d;
    fb[NB - 1] = 1'b1;
    t0 = s + 1 + GAP;
    setf(s + 1, t0 + BC * NB - 1, F_BUSY, 1);
    setf(t0, t0 + BC * NB - 1, F_OE, 1);
    for (int j = 0; j < NB; j++) setf(t0 + BC * j, t0 + BC * j + BC - 1, F_OUT, {7'b0, fb[j]});
    setf(t0, LAST, F_RDY, 1);
  endfunction

  // Frame whose start bit is first on the pad in cycle c0; pad_in_r sees it
  // one cycle later and the stop sample lands mid stop bit.
  function automatic void model_frame(input int c0, input logic [DW-1:0] d, input logic good);
    int t0, s;
    t0 = c0 + 1;
    s  = t0 + BC / 2 + BC * (DW + PB + 1);
    setf(t0 + 1, s, F_BUSY, 1);
    if (good) begin
      setf(s + 1, s + 1, F_RXV, 1);
      setf(s + 1, LAST, F_RXD, d);
      if (m_full) begin
        model_resp(s, m_hold);
        m_full = 1'b0;
      end
    end else begin
      setf(s + 1, s + 1, F_ERR, 1);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n && cyc < NCYC) begin
      chk("oe", {31'b0, probe_oe}, {31'b0, ex[cyc].oe});
      if (ex[cyc].oe) chk("pad", {31'b0, pad}, {31'b0, ex[cyc].out});
      chk("busy", {31'b0, busy}, {31'b0, ex[cyc].busy});
      chk("rx_valid", {31'b0, rx_valid}, {31'b0, ex[cyc].rxv});
      chk("err", {31'b0, err}, {31'b0, ex[cyc].err});
      chk("tx_ready", {31'b0, tx_ready}, {31'b0, ex[cyc].rdy});
      chk("rx_data", {24'b0, rx_data}, {24'b0, ex[cyc].rxd});
    end
  end

  task automatic load(input logic [DW-1:0] d);
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    setf(cyc + 1, LAST, F_RDY, 0);
    m_full = 1'b1;
    m_hold = d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic stop, input logic par, output int c0);
    logic [NB-1:0] fb;
    fb = '0;
    for (int i = 0; i < DW; i++) fb[1 + i] = d[i];
    if (PB == 1) fb[DW + 1] = par;
    fb[NB - 1] = stop;
    @(posedge clk); #1;
    c0 = cyc;
    model_frame(c0, d, stop && (PB == 0 || par == ^d));
    for (int j = 0; j < NB; j++) begin
      init_low = ~fb[j];
      repeat (BC) begin
        @(posedge clk); #1;
      end
    end
    init_low = 1'b0;
  endtask

  // which: 0 rx_valid, 1 err, 2 pad output enable
  task automatic wait_for(input string nm, input int which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && rx_valid) || (which == 1 && err) || (which == 2 && probe_oe)) begin
        at = cyc;
        break;
      end
    end
    n_tests++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL %s: event absent, got timeout, expected within %0d cycles", nm, limit);
    end
  endtask

  task automatic wait_idle(input string nm);
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk(nm, ok, 1);
    repeat (3) @(posedge clk);
  endtask

  // Called at the negedge of the first driven cycle; samples each bit mid-way.
  task automatic capture(output logic [NB-1:0] bits);
    bits = '0;
    @(negedge clk);
    for (int j = 0; j < NB; j++) begin
      bits[j] = pad;
      repeat (BC) @(negedge clk);
    end
  endtask

`ifdef SW_RESP_PARITY_EN
  localparam int            RXV_LAT = 44;
  localparam logic [NB-1:0] RESP_3C = 11'h478;
  localparam logic [NB-1:0] RESP_55 = 11'h4AA;
  localparam logic [NB-1:0] RESP_99 = 11'h532;
`else
  localparam int            RXV_LAT = 40;
  localparam logic [NB-1:0] RESP_3C = 10'h278;
  localparam logic [NB-1:0] RESP_55 = 10'h2AA;
  localparam logic [NB-1:0] RESP_99 = 10'h332;
`endif

  initial begin
    int            c0, at_v, at_o, at_e;
    logic [NB-1:0] bits;

    model_reset(0);

    @(negedge clk);
    chk("reset_tx_ready", {31'b0, tx_ready}, 1);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_rx_valid", {31'b0, rx_valid}, 0);
    chk("reset_err", {31'b0, err}, 0);
    chk("reset_rx_data", {24'b0, rx_data}, 0);
    chk("reset_oe", {31'b0, probe_oe}, 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(posedge clk);

    // Receive without response
    send(8'hA5, 1'b1, ^8'hA5, c0);
    wait_for("rx_a5", 0, 20, at_v);
    chk("rx_a5_data", {24'b0, rx_data}, 32'hA5);
    chk("rx_a5_latency", at_v - c0, RXV_LAT);
    chk("rx_a5_busy_low", {31'b0, busy}, 0);
    wait_idle("idle_a5");

    // Receive with response 0x3C
    load(8'h3C);
    @(negedge clk);
    chk("load_3c_ready", {31'b0, tx_ready}, 0);
    send(8'h12, 1'b1, ^8'h12, c0);
    wait_for("rx_12", 0, 20, at_v);
    chk("rx_12_data", {24'b0, rx_data}, 32'h12);
    wait_for("oe_3c", 2, 40, at_o);
    chk("turnaround", at_o - at_v, 6);
    chk("ready_at_tx_start", {31'b0, tx_ready}, 1);
    capture(bits);
    chk("resp_3c_bits", {{(32 - NB){1'b0}}, bits}, {{(32 - NB){1'b0}}, RESP_3C});
    wait_idle("idle_12");

    // Glitch on idle line
    @(posedge clk); #1;
    init_low = 1'b1;
    setf(cyc + 2, cyc + 1 + BC / 2, F_BUSY, 1);
    @(posedge clk); #1;
    init_low = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", {31'b0, busy}, 0);

    // Framing error keeps pending response
    load(8'h55);
    send(8'hFF, 1'b0, ^8'hFF, c0);
    wait_for("ferr", 1, 20, at_e);
    chk("ferr_rx_data", {24'b0, rx_data}, 32'h12);
    chk("ferr_pending", {31'b0, tx_ready}, 0);
    wait_idle("idle_ferr");
    send(8'h81, 1'b1, ^8'h81, c0);
    wait_for("rx_81", 0, 20, at_v);
    wait_for("oe_55", 2, 40, at_o);
    capture(bits);
    chk("resp_55_bits", {{(32 - NB){1'b0}}, bits}, {{(32 - NB){1'b0}}, RESP_55});
    wait_idle("idle_81");

    // Load accepted during TX is used for the next frame
    load(8'hE7);
    send(8'h00, 1'b1, 1'b0, c0);
    wait_for("oe_e7", 2, 60, at_o);
    chk("tx_ready_in_tx", {31'b0, tx_ready}, 1);
    load(8'h99);
    @(negedge clk);
    chk("load_in_tx_ready", {31'b0, tx_ready}, 0);
    wait_idle("idle_e7");
    send(8'h11, 1'b1, ^8'h11, c0);
    wait_for("oe_99", 2, 60, at_o);
    capture(bits);
    chk("resp_99_bits", {{(32 - NB){1'b0}}, bits}, {{(32 - NB){1'b0}}, RESP_99});
    wait_idle("idle_11");

`ifdef SW_RESP_PARITY_EN
    // Parity: bad parity gives err and no response, good parity answers
    load(8'h3C);
    send(8'h07, 1'b1, 1'b0, c0);
    wait_for("par_err", 1, 20, at_e);
    chk("par_err_pending", {31'b0, tx_ready}, 0);
    chk("par_err_rx_data", {24'b0, rx_data}, 32'h11);
    wait_idle("idle_par_bad");
    send(8'h07, 1'b1, 1'b1, c0);
    wait_for("par_ok", 0, 20, at_v);
    chk("par_ok_data", {24'b0, rx_data}, 32'h07);
    wait_for("oe_par", 2, 40, at_o);
    capture(bits);
    chk("resp_par_bit", {31'b0, bits[DW + 1]}, 0);
    wait_idle("idle_par_ok");
`endif

    // Asynchronous reset during a TX data bit
    load(8'hC3);
    send(8'h01, 1'b1, ^8'h01, c0);
    wait_for("oe_c3", 2, 60, at_o);
    repeat (2 * BC) @(negedge clk);
    chk_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_oe", {31'b0, probe_oe}, 0);
    chk("rst_pad", {31'b0, pad}, 1);
    chk("rst_tx_ready", {31'b0, tx_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_rx_data", {24'b0, rx_data}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset(cyc);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 0);
    send(8'h5A, 1'b1, ^8'h5A, c0);
    wait_for("rx_5a", 0, 20, at_v);
    chk("rx_5a_data", {24'b0, rx_data}, 32'h5A);
    wait_idle("idle_5a");

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
